// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: control FSM for a multicycle RV32 subset datapath with a
// unified memory handshake, an illegal-instruction trap and a retired-instruction counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        memready,
  output logic        pcen,
  output logic        iord,
  output logic        memrd,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  resultsrc,
  output logic [2:0]  alucontrol,
  output logic [3:0]  state,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXECI  = 4'd8,
    S_BEQ    = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     cur_state;
  state_t     nxt_state;
  logic       rtype_legal;
  logic [2:0] rtype_alu;
  logic       pcwrite;
  logic       branch;
  logic       retire;

  always_comb begin
    rtype_legal = 1'b1;
    rtype_alu   = 3'b000;
    case (funct3)
      3'b000: begin
        if (funct7 == 7'b0000000)      rtype_alu = 3'b010;
        else if (funct7 == 7'b0100000) rtype_alu = 3'b110;
        else                           rtype_legal = 1'b0;
      end
      3'b111:  rtype_alu = 3'b000;
      3'b110:  rtype_alu = 3'b001;
      3'b010:  rtype_alu = 3'b111;
      default: rtype_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  if (memready) nxt_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
          OP_RTYPE:          nxt_state = S_EXECR;
          OP_ITYPE:          nxt_state = S_EXECI;
          OP_BRANCH:         nxt_state = S_BEQ;
          default:           nxt_state = S_TRAP;
        endcase
      end
      S_MEMADR: nxt_state = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memready) nxt_state = S_MEMWB;
      S_MEMWB:  nxt_state = S_FETCH;
      S_MEMWR:  if (memready) nxt_state = S_FETCH;
      S_EXECR:  nxt_state = rtype_legal ? S_ALUWB : S_TRAP;
      S_EXECI:  nxt_state = (funct3 == 3'b000) ? S_ALUWB : S_TRAP;
      S_ALUWB:  nxt_state = S_FETCH;
      S_BEQ:    nxt_state = S_FETCH;
      S_TRAP:   nxt_state = S_TRAP;
      default:  nxt_state = S_TRAP;
    endcase
  end

  assign retire = (cur_state == S_MEMWB) || (cur_state == S_ALUWB) ||
                  (cur_state == S_BEQ)   || ((cur_state == S_MEMWR) && memready);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      cur_state <= S_FETCH;
      instret   <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      if (retire) instret <= instret + 32'd1;
    end
  end

  // Enables are killed combinationally while reset is low so nothing is
  // written in the cycle the reset is sampled.
  always_comb begin
    iord       = 1'b0;
    memrd      = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    alucontrol = 3'b000;
    case (cur_state)
      S_FETCH: begin
        memrd      = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        resultsrc  = 2'b10;
        irwrite    = memready;
        pcwrite    = memready;
      end
      S_DECODE: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
      end
      S_MEMADR, S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
      end
      S_MEMRD: begin
        iord  = 1'b1;
        memrd = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = rtype_alu;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = 3'b110;
        branch     = 1'b1;
      end
      default: ;
    endcase
    if (!reset_) begin
      memrd    = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = cur_state;
  assign trap  = (cur_state == S_TRAP);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl: directed scenario tests for the multicycle control FSM.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        zero;
  logic        memready;
  logic        pcen, iord, memrd, memwrite, irwrite, regwrite, trap;
  logic [1:0]  alusrca, alusrcb, resultsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  multicycle_ctrl dut (
    .clk(clk), .reset_(reset_), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .memready(memready), .pcen(pcen), .iord(iord), .memrd(memrd),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .resultsrc(resultsrc), .alucontrol(alucontrol), .state(state),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_   = 1'b0;
    memready = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", trap); end
    memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_stall_state: got %0d expected 0", state); end
      checks++; if ({memrd, irwrite, pcen, iord} !== 4'b1000) begin errors++; $display("FAIL fetch_stall_ctl: got %b expected 1000", {memrd, irwrite, pcen, iord}); end
    end
    checks++; if ({alusrca, alusrcb, resultsrc, alucontrol} !== 9'b00_10_10_010) begin errors++; $display("FAIL fetch_selects: got %b expected 001010010", {alusrca, alusrcb, resultsrc, alucontrol}); end
    memready = 1'b1;
    #1;
    checks++; if ({irwrite, pcen} !== 2'b11) begin errors++; $display("FAIL fetch_ready: got %b expected 11", {irwrite, pcen}); end
    reset_ = 1'b0;
    #1;
    checks++; if ({irwrite, pcen, memrd} !== 3'b000) begin errors++; $display("FAIL reset_gating: got %b expected 000", {irwrite, pcen, memrd}); end
    tick();
    reset_ = 1'b1;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_hold_fetch: got %0d expected 0", state); end
  endtask

  task automatic test_addi();
    logic [3:0] exp_s [5];
    exp_s = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd0};
    do_reset();
    opcode = OP_ITYPE; funct3 = 3'b000; funct7 = 7'd0; memready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      checks++; if (regwrite !== (exp_s[i] == 4'd7)) begin errors++; $display("FAIL addi_regwrite[%0d]: got %b expected %b", i, regwrite, exp_s[i] == 4'd7); end
      if (i == 2) begin
        checks++; if ({alusrca, alusrcb, alucontrol} !== 7'b10_01_010) begin errors++; $display("FAIL execi_selects: got %b expected 1001010", {alusrca, alusrcb, alucontrol}); end
      end
      if (i < 4) tick();
    end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL addi_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_load_wait();
    int cyc;
    do_reset();
    opcode = OP_LOAD; funct3 = 3'b010; memready = 1'b1;
    tick(); cyc = 1;
    tick(); cyc++;
    tick(); cyc++;
    memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== 4'd3) begin errors++; $display("FAIL ld_wait_state[%0d]: got %0d expected 3", i, state); end
      checks++; if ({iord, memrd, memwrite} !== 3'b110) begin errors++; $display("FAIL ld_wait_ctl[%0d]: got %b expected 110", i, {iord, memrd, memwrite}); end
      tick(); cyc++;
    end
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL ld_still_memrd: got %0d expected 3", state); end
    memready = 1'b1;
    tick(); cyc++;
    #1;
    checks++; if (state !== 4'd4) begin errors++; $display("FAIL ld_memwb_state: got %0d expected 4", state); end
    checks++; if ({regwrite, resultsrc} !== 3'b1_01) begin errors++; $display("FAIL ld_memwb_ctl: got %b expected 101", {regwrite, resultsrc}); end
    tick(); cyc++;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL ld_back_to_fetch: got %0d expected 0", state); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL ld_cycle_count: got %0d expected 8", cyc); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL ld_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_beq();
    do_reset();
    opcode = OP_BRANCH; funct3 = 3'b000; memready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      tick(); tick();
      #1;
      checks++; if (state !== 4'd9) begin errors++; $display("FAIL beq_state z=%0d: got %0d expected 9", z, state); end
      checks++; if (pcen !== z[0]) begin errors++; $display("FAIL beq_pcen z=%0d: got %b expected %b", z, pcen, z[0]); end
      checks++; if (alucontrol !== 3'b110) begin errors++; $display("FAIL beq_aluctl: got %b expected 110", alucontrol); end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq_return z=%0d: got %0d expected 0", z, state); end
      checks++; if (instret !== 32'(2 - z)) begin errors++; $display("FAIL beq_instret z=%0d: got %0d expected %0d", z, instret, 2 - z); end
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype_trap();
    do_reset();
    opcode = OP_RTYPE; funct3 = 3'b000; funct7 = 7'b0100000; memready = 1'b1;
    tick(); tick();
    #1;
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL sub_state: got %0d expected 6", state); end
    checks++; if (alucontrol !== 3'b110) begin errors++; $display("FAIL sub_aluctl: got %b expected 110", alucontrol); end
    tick(); tick();
    checks++; if (state !== 4'd0 || instret !== 32'd1) begin errors++; $display("FAIL sub_retire: got state %0d instret %0d expected 0 1", state, instret); end
    funct3 = 3'b100; funct7 = 7'd0;
    tick(); tick();
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL bad_r_execr: got %0d expected 6", state); end
    tick();
    #1;
    checks++; if (state !== 4'd15 || trap !== 1'b1) begin errors++; $display("FAIL bad_r_trap: got state %0d trap %b expected 15 1", state, trap); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (state !== 4'd15 || {pcen, irwrite, regwrite, memrd, memwrite} !== 5'b0) begin
        errors++; $display("FAIL trap_hold[%0d]: got state %0d enables %b expected 15 00000", i, state, {pcen, irwrite, regwrite, memrd, memwrite});
      end
    end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL trap_instret: got %0d expected 1", instret); end
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    #1;
    checks++; if (state !== 4'd0 || trap !== 1'b0) begin errors++; $display("FAIL trap_reset: got state %0d trap %b expected 0 0", state, trap); end
    opcode = 7'b1111111;
    memready = 1'b1;
    tick(); tick();
    checks++; if (state !== 4'd15) begin errors++; $display("FAIL bad_opcode_trap: got %0d expected 15", state); end
  endtask

  task automatic test_store_reset();
    do_reset();
    opcode = OP_STORE; funct3 = 3'b010; memready = 1'b1;
    tick(); tick(); tick();
    #1;
    checks++; if (state !== 4'd5 || {iord, memwrite, memrd, regwrite} !== 4'b1100) begin
      errors++; $display("FAIL sw_memwr: got state %0d ctl %b expected 5 1100", state, {iord, memwrite, memrd, regwrite});
    end
    tick();
    checks++; if (state !== 4'd0 || instret !== 32'd1) begin errors++; $display("FAIL sw_retire: got state %0d instret %0d expected 0 1", state, instret); end
    tick();
    memready = 1'b0;
    tick(); tick();
    #1;
    checks++; if (state !== 4'd5 || memwrite !== 1'b1) begin errors++; $display("FAIL sw_wait: got state %0d memwrite %b expected 5 1", state, memwrite); end
    reset_ = 1'b0;
    #1;
    checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL sw_reset_gate: got %b expected 0", memwrite); end
    tick();
    reset_ = 1'b1;
    #1;
    checks++; if (state !== 4'd0 || instret !== 32'd0) begin errors++; $display("FAIL sw_reset_after: got state %0d instret %0d expected 0 0", state, instret); end
  endtask

  task automatic test_wrap();
    do_reset();
    dut.instret = 32'hFFFF_FFFF;
    opcode = OP_ITYPE; funct3 = 3'b000; funct7 = 7'd0; memready = 1'b1;
    tick(); tick(); tick();
    #1;
    checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_before: got %h expected ffffffff", instret); end
    tick();
    checks++; if (instret !== 32'h0000_0000 || state !== 4'd0) begin errors++; $display("FAIL wrap_after: got instret %h state %0d expected 00000000 0", instret, state); end
  endtask

  initial begin
    reset_ = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0; memready = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_beq();
    test_rtype_trap();
    test_store_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 reset_  in  1  reset, synchronous, active-low; sampled on posedge clk only.
REQ-003 opcode  in  7  instr[6:0] from instruction register.
REQ-004 funct3  in  3  instr[14:12].
REQ-005 funct7  in  7  instr[31:25].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 memready  in  1  unified memory access done this cycle.
REQ-008 pcen  out  1  PC register enable; equals pcwrite | (branch & zero).
REQ-009 iord  out  1  memory address select: 0 = PC, 1 = ALUOut register.
REQ-010 memrd, memwrite, irwrite, regwrite  out  1 each  memory read request, memory write request, instruction register load, register file write.
REQ-011 alusrca  out  2  00 = PC, 01 = OldPC, 10 = A register.
REQ-012 alusrcb  out  2  00 = B register, 01 = sign-extended immediate, 10 = constant 4.
REQ-013 resultsrc  out  2  00 = ALUOut register, 01 = Data register, 10 = live ALU result.
REQ-014 alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-015 state  out  4  current state code; trap  out  1  illegal instruction halt; instret  out  32  retired-instruction count.

Function
REQ-016 The block SHALL be a Moore FSM, except that irwrite, pcen and the FETCH/MEMRD/MEMWR exits SHALL be qualified by memready as stated below.
REQ-017 State codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, ALUWB 7, EXECI 8, BEQ 9, TRAP 15.
REQ-018 FETCH SHALL drive iord=0, memrd=1, alusrca=00, alusrcb=10, alucontrol=010, resultsrc=10, and assert irwrite and pcwrite only when memready=1; it SHALL stay in FETCH while memready=0.
REQ-019 DECODE SHALL drive alusrca=01, alusrcb=01, alucontrol=010 to latch the branch target in ALUOut, then go to: MEMADR for 0000011/0100011, EXECR for 0110011, EXECI for 0010011, BEQ for 1100011, and TRAP for any other opcode.
REQ-020 MEMADR SHALL drive alusrca=10, alusrcb=01, alucontrol=010, then go to MEMRD for opcode 0000011 and to MEMWR otherwise.
REQ-021 MEMRD SHALL drive iord=1, memrd=1, and hold until memready=1, then go to MEMWB.
REQ-022 MEMWB SHALL drive resultsrc=01, regwrite=1, then go to FETCH.
REQ-023 MEMWR SHALL drive iord=1, memwrite=1, and hold until memready=1, then go to FETCH.
REQ-024 EXECR SHALL drive alusrca=10, alusrcb=00, with alucontrol from funct3/funct7: 000/0000000 add 010, 000/0100000 sub 110, 111 and 000, 110 or 001, 010 slt 111; any other combination SHALL go to TRAP instead of ALUWB.
REQ-025 EXECI (funct3=000 only, else TRAP) SHALL drive alusrca=10, alusrcb=01, alucontrol=010, then go to ALUWB.
REQ-026 ALUWB SHALL drive resultsrc=00, regwrite=1, then go to FETCH.
REQ-027 BEQ SHALL drive alusrca=10, alusrcb=00, alucontrol=110, resultsrc=00, branch=1, then go to FETCH.
REQ-028 TRAP SHALL hold all enables (pcen, irwrite, regwrite, memrd, memwrite) at 0, assert trap=1, and remain in TRAP until reset.
REQ-029 In every state not listed above, the enables SHALL be 0 and the mux selects SHALL be 00.
REQ-030 instret SHALL increment by 1 (mod 2^32, wrapping from FFFFFFFF to 0) on each transition into FETCH from MEMWB, MEMWR with memready=1, ALUWB or BEQ; it SHALL NOT increment on entry to TRAP.
REQ-031 memwrite and regwrite SHALL never be 1 in the same cycle; memrd and memwrite SHALL never be 1 in the same cycle.

Reset
REQ-032 While reset_=0 at a posedge clk, the next state SHALL be FETCH, instret SHALL be 0 and trap SHALL be 0, regardless of the current state (including TRAP or a pending memory wait).
REQ-033 During the cycle in which reset_=0 is sampled, pcen, irwrite, regwrite, memwrite and memrd SHALL be forced to 0.

Verification
REQ-034 ADDI: reset, then FETCH (memready=1) with opcode 0010011 and funct3 000 -> state sequence 0,1,8,7,0; regwrite=1 only in state 7; instret=1.
REQ-035 LD with memready held 0 for 3 cycles in MEMRD -> state stays 3 for 3 cycles, then goes 4 then 0; total 8 cycles from FETCH to FETCH.
REQ-036 BEQ with zero=1 -> pcen=1 in state 9; with zero=0 -> pcen=0 in state 9; both cases return to 0 and increment instret.
REQ-037 R-type funct3=000, funct7=0100000 -> alucontrol=110 in EXECR; funct3=100 -> TRAP, trap=1, instret unchanged; holding for 10 cycles keeps state 15.
REQ-038 Assert reset_=0 in MEMWR while memwrite=1 -> memwrite=0 in the same cycle, state 0 next, instret 0; preloaded instret FFFFFFFF plus one retire -> 00000000.
